load_store_unit: RTL and testbench

- Multi-cycle load/store unit sitting directly downstream of the single-cycle core's address/store-data datapath.
- Replaces the ideal zero-latency data memory with a handshaked, word-addressed memory bus.
- Adds byte and halfword access (LB/LH/LBU/LHU/SB/SH) alongside LW/SW.
- Flags misaligned, unsupported and timed-out accesses back to the core.

---
 rtl/lsu_pkg.sv | 16 +
 rtl/load_store_unit_if.sv | 36 +++
 rtl/lsu_align.sv | 70 +++++++
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I load/store funct3 codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Core-request/response and word-addressed memory bus signals of the load/store unit.
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // The unit itself: serves core requests and masters the memory bus.
    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_error, busy,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    // The environment: core issuing requests plus the memory answering them.
    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_error, busy,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: store replication/strobes, load extraction/extension, legality checks.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        write,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic [31:0] ld_data,
    output logic        misaligned,
    output logic        unsupported
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        case (off)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = off[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_W:    ld_data = rdata;
            F3_BU:   ld_data = {24'd0, ld_byte};
            F3_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = '0;
        endcase

        st_wdata = '0;
        st_wstrb = '0;
        if (write) begin
            case (funct3)
                F3_B: begin
                    st_wdata = {4{wdata[7:0]}};
                    st_wstrb = 4'b0001 << off;
                end
                F3_H: begin
                    st_wdata = {2{wdata[15:0]}};
                    st_wstrb = off[1] ? 4'b1100 : 4'b0011;
                end
                F3_W: begin
                    st_wdata = wdata;
                    st_wstrb = 4'b1111;
                end
                default: ;
            endcase
        end

        if (write)
            unsupported = !(funct3 inside {F3_B, F3_H, F3_W});
        else
            unsupported = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

        case (funct3)
            F3_H, F3_HU: misaligned = off[0];
            F3_W:        misaligned = |off;
            default:     misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: accepts one core request at a time, runs it on a
// handshaked word bus with a timeout, and returns a single-cycle response pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;

    logic        idle;
    logic        req_ready;
    logic        accept;
    logic [2:0]  al_funct3;
    logic        al_write;
    logic [1:0]  al_off;
    logic [31:0] al_st_wdata;
    logic [31:0] al_ld_data;
    logic [3:0]  al_st_wstrb;
    logic        al_misaligned;
    logic        al_unsupported;

    assign idle      = (state_q == ST_IDLE);
    assign req_ready = idle && !reset;
    assign accept    = bus.req_valid && req_ready;

    // One aligner serves both phases: in IDLE it sees the incoming request
    // (checks + store lanes), afterwards the captured load for extraction.
    assign al_funct3 = idle ? bus.req_funct3    : funct3_q;
    assign al_write  = idle ? bus.req_write     : mem_we_q;
    assign al_off    = idle ? bus.req_addr[1:0] : off_q;

    lsu_align u_align (
        .funct3      (al_funct3),
        .write       (al_write),
        .off         (al_off),
        .wdata       (bus.req_wdata),
        .rdata       (bus.mem_rdata),
        .st_wdata    (al_st_wdata),
        .st_wstrb    (al_st_wstrb),
        .ld_data     (al_ld_data),
        .misaligned  (al_misaligned),
        .unsupported (al_unsupported)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    funct3_d = bus.req_funct3;
                    off_d    = bus.req_addr[1:0];
                    if (al_misaligned || al_unsupported) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d     = ST_MEM;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.req_write;
                        mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                        mem_wdata_d = al_st_wdata;
                        mem_wstrb_d = al_st_wstrb;
                    end
                end
            end
            ST_MEM: begin
                if (bus.mem_ack) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_rdata_d = mem_we_q ? '0 : al_ld_data;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                    resp_rdata_d = '0;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            funct3_q     <= '0;
            off_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.busy       = !idle;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wstrb  = mem_wstrb_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_error = resp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 4-cycle memory timeout.
module tb_load_store_unit;

    logic clk;
    logic reset;
    int unsigned checks;
    int unsigned errors;

    load_store_unit_if bus ();

    load_store_unit #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single edge; returns in the cycle after acceptance.
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        step();
        bus.req_valid  = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] word, input logic [31:0] exp);
        issue(1'b0, f3, addr, 32'h0);
        chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd1);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
        chk({tag, "_mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = word;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, "_resp_error"}, 32'(bus.resp_error), 32'd0);
        chk({tag, "_rdata"}, bus.resp_rdata, exp);
        step();
        chk({tag, "_idle_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp_wdata,
                            input logic [3:0] exp_wstrb);
        issue(1'b1, f3, addr, wd);
        chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd1);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd1);
        chk({tag, "_mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
        chk({tag, "_wdata"}, bus.mem_wdata, exp_wdata);
        chk({tag, "_wstrb"}, 32'(bus.mem_wstrb), 32'(exp_wstrb));
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, "_resp_error"}, 32'(bus.resp_error), 32'd0);
        chk({tag, "_rdata"}, bus.resp_rdata, 32'h0);
        step();
    endtask

    task automatic do_bad(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr);
        issue(wr, f3, addr, 32'h5555_AAAA);
        chk({tag, "_no_mem_req"}, 32'(bus.mem_req), 32'd0);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, "_resp_error"}, 32'(bus.resp_error), 32'd1);
        chk({tag, "_rdata"}, bus.resp_rdata, 32'h0);
        step();
        chk({tag, "_pulse_end"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_error_held"}, 32'(bus.resp_error), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 32'h0;

        step();
        step();
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // SW, with a competing request held during MEM that must be dropped
        issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        chk("sw_mem_req", 32'(bus.mem_req), 32'd1);
        chk("sw_mem_addr", bus.mem_addr, 32'h0000_0100);
        chk("sw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("sw_wstrb", 32'(bus.mem_wstrb), 32'hF);
        chk("sw_busy", 32'(bus.busy), 32'd1);
        chk("sw_ready_low", 32'(bus.req_ready), 32'd0);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_0200;
        bus.mem_ack    = 1'b1;
        step();
        bus.req_valid = 1'b0;
        bus.mem_ack   = 1'b0;
        chk("sw_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("sw_resp_error", 32'(bus.resp_error), 32'd0);
        chk("sw_rdata", bus.resp_rdata, 32'h0);
        chk("sw_req_dropped", 32'(bus.mem_req), 32'd0);
        step();
        chk("sw_idle_busy", 32'(bus.busy), 32'd0);
        chk("sw_idle_no_resp", 32'(bus.resp_valid), 32'd0);

        // Stray ack while idle
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("stray_ack_busy", 32'(bus.busy), 32'd0);
        chk("stray_ack_resp", 32'(bus.resp_valid), 32'd0);

        do_store("sb", 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b1000);
        do_store("sh", 3'b001, 32'h0000_0102, 32'h1234_BEEF, 32'hBEEF_BEEF, 4'b1100);
        do_store("sb0", 3'b000, 32'h0000_0200, 32'h0000_0011, 32'h1111_1111, 4'b0001);

        do_load("lb", 3'b000, 32'h0000_0102, 32'h12F0_3456, 32'hFFFF_FFF0);
        do_load("lbu", 3'b100, 32'h0000_0102, 32'h12F0_3456, 32'h0000_00F0);
        do_load("lh", 3'b001, 32'h0000_0102, 32'h12F0_3456, 32'h0000_12F0);
        do_load("lh_neg", 3'b001, 32'h0000_0100, 32'h0000_8001, 32'hFFFF_8001);
        do_load("lhu", 3'b101, 32'h0000_0100, 32'h0000_8001, 32'h0000_8001);
        do_load("lw", 3'b010, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'hCAFE_F00D);

        do_bad("lw_mis", 1'b0, 3'b010, 32'h0000_0101);
        do_bad("ld_f3_011", 1'b0, 3'b011, 32'h0000_0100);
        do_bad("sh_mis", 1'b1, 3'b001, 32'h0000_0103);
        do_bad("st_f3_100", 1'b1, 3'b100, 32'h0000_0100);

        // Timeout: 4 cycles of mem_req, then error response
        issue(1'b0, 3'b010, 32'h0000_0108, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_mem_req_%0d", i), 32'(bus.mem_req), 32'd1);
            step();
        end
        chk("to_mem_req_off", 32'(bus.mem_req), 32'd0);
        chk("to_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("to_resp_error", 32'(bus.resp_error), 32'd1);
        chk("to_rdata", bus.resp_rdata, 32'h0);
        step();
        chk("to_ready", 32'(bus.req_ready), 32'd1);
        chk("to_pulse_end", 32'(bus.resp_valid), 32'd0);

        // Ack on the final allowed cycle completes normally
        issue(1'b0, 3'b010, 32'h0000_010C, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("late_mem_req_%0d", i), 32'(bus.mem_req), 32'd1);
            step();
        end
        chk("late_mem_req_3", 32'(bus.mem_req), 32'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0BAD_F00D;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        chk("late_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("late_resp_error", 32'(bus.resp_error), 32'd0);
        chk("late_rdata", bus.resp_rdata, 32'h0BAD_F00D);
        step();

        // Reset in the second MEM cycle abandons the transaction
        issue(1'b0, 3'b010, 32'h0000_0110, 32'h0);
        step();
        chk("rmid_mem_req_before", 32'(bus.mem_req), 32'd1);
        reset = 1'b1;
        step();
        chk("rmid_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rmid_busy", 32'(bus.busy), 32'd0);
        chk("rmid_ready_in_reset", 32'(bus.req_ready), 32'd0);
        chk("rmid_resp", 32'(bus.resp_valid), 32'd0);
        reset = 1'b0;
        step();
        chk("rmid_no_resp", 32'(bus.resp_valid), 32'd0);
        do_load("after_rst_lw", 3'b010, 32'h0000_0114, 32'h0102_0304, 32'h0102_0304);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
